// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment patterns are logical active-high, bit0 = segment a.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Counter width for a value range 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Slot/digit scan counters for sevenseg_scan_ctrl: slot position s, digit index d,
// enable hold and the registered end-of-frame pulse.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  output logic                             slot_start,
  output logic [idx_w(SLOT_CYCLES)-1:0]    s,
  output logic [idx_w(N_DIGITS)-1:0]       d,
  output logic                             frame_tick
);

  localparam int SW = idx_w(SLOT_CYCLES);
  localparam int DW = idx_w(N_DIGITS);
  localparam logic [SW-1:0] S_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(N_DIGITS - 1);

  logic s_last;
  logic d_last;

  assign s_last     = (s == S_LAST);
  assign d_last     = (d == D_LAST);
  // High in the cycle whose edge wraps s to 0 and advances d.
  assign slot_start = en && s_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      s          <= '0;
      d          <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= en && s_last && d_last;
      if (en) begin
        if (s_last) begin
          s <= '0;
          d <= d_last ? '0 : d + DW'(1);
        end else begin
          s <= s + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit dp/blanking, guard interval
// and compile-time polarity. Optional PWM dimming via `define SEVENSEG_DIM_EN.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SLOT_CYCLES    = 1024,
  parameter int GUARD_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  seg_t                                seg_in [N_DIGITS],
  input  logic [N_DIGITS-1:0]                 dp_in,
  input  logic [N_DIGITS-1:0]                 blank_in,
`ifdef SEVENSEG_DIM_EN
  input  logic [$clog2(SLOT_CYCLES+1)-1:0]    brightness,
`endif
  output seg_t                                seg_out,
  output logic                                dp_out,
  output logic [N_DIGITS-1:0]                 an,
  output logic                                frame_tick
);

  localparam int SW = idx_w(SLOT_CYCLES);
  localparam int DW = idx_w(N_DIGITS);

  logic          slot_start;
  logic [SW-1:0] s;
  logic [DW-1:0] d;
  logic [DW-1:0] d_nxt;

  sevenseg_slot_timer #(
    .N_DIGITS    (N_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .slot_start (slot_start),
    .s          (s),
    .d          (d),
    .frame_tick (frame_tick)
  );

  function automatic seg_t seg_phys(input seg_t v);
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic dp_phys(input logic v);
    return (SEG_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [N_DIGITS-1:0] an_phys(input logic [N_DIGITS-1:0] v);
    return (AN_ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  assign d_nxt = (d == DW'(N_DIGITS - 1)) ? '0 : d + DW'(1);

  // Stage p0: per-slot capture of the digit about to be shown.
  seg_t seg_p0;
  logic dp_p0;
  logic blank_p0;
  logic dim_ok_p0;
  logic lit_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_p0 <= 1'b1;
    end else if (slot_start) begin
      blank_p0 <= blank_in[d_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (slot_start) begin
      seg_p0 <= seg_in[d_nxt];
      dp_p0  <= dp_in[d_nxt];
    end
  end

`ifdef SEVENSEG_DIM_EN
  logic [$clog2(SLOT_CYCLES+1)-1:0] bright_p0;

  always_ff @(posedge clk) begin
    if (slot_start) begin
      bright_p0 <= brightness;
    end
  end

  always_comb dim_ok_p0 = (int'(s) - GUARD_CYCLES) < int'(bright_p0);
`else
  always_comb dim_ok_p0 = 1'b1;
`endif

  // Reset and disable fold into the lit term so the output stage needs no reset of its own.
  always_comb lit_p0 = en && !reset && !blank_p0 && (int'(s) >= GUARD_CYCLES) && dim_ok_p0;

  // Stage p1: registered pins, polarity applied last.
  always_ff @(posedge clk) begin
    seg_out <= seg_phys(lit_p0 ? seg_p0 : SEG_BLANK);
    dp_out  <= dp_phys(lit_p0 && dp_p0);
    an      <= an_phys(lit_p0 ? (N_DIGITS'(1) << d) : '0);
  end

endmodule
